// File: rtl/icache_axi_refill_pkg.sv
// Shared AXI encodings, cache geometry and refill FSM state for the icache refill master.
package icache_axi_refill_pkg;

  localparam int DATA_WIDTH          = 32;
  localparam int ADDR_WIDTH          = 32;
  localparam int AXI_ID_WIDTH        = 4;
  localparam int AXI_ARLEN_WIDTH     = 8;
  localparam int ICACHE_LINE_SIZE    = 32;
  localparam int ICACHE_LINE_OFFSET  = $clog2(ICACHE_LINE_SIZE);
  localparam int ICACHE_REFILL_BEATS = ICACHE_LINE_SIZE / (DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'd0,
    AXI_BURST_INCR  = 2'd1,
    AXI_BURST_WRAP  = 2'd2,
    AXI_BURST_RSVD  = 2'd3
  } axi_burst_type_t;

  typedef enum logic [2:0] {
    AXI_SIZE_1B   = 3'd0,
    AXI_SIZE_2B   = 3'd1,
    AXI_SIZE_4B   = 3'd2,
    AXI_SIZE_8B   = 3'd3,
    AXI_SIZE_16B  = 3'd4,
    AXI_SIZE_32B  = 3'd5,
    AXI_SIZE_64B  = 3'd6,
    AXI_SIZE_128B = 3'd7
  } axi_size_t;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'd0,
    AXI_RESP_EXOKAY = 2'd1,
    AXI_RESP_SLVERR = 2'd2,
    AXI_RESP_DECERR = 2'd3
  } axi_resp_t;

  typedef enum logic [1:0] {
    REFILL_IDLE,
    REFILL_AR,
    REFILL_R,
    REFILL_DONE
  } icache_refill_state_t;

endpackage

// File: rtl/icache_axi_refill.sv
// Refills one icache line on a miss: single INCR read burst, beats assembled into a line buffer.
module icache_axi_refill
  import icache_axi_refill_pkg::*;
#(
  parameter logic [AXI_ID_WIDTH-1:0] AXI_ID = 4'd0,
  parameter int LINE_BYTES = ICACHE_LINE_SIZE,
  parameter int BEATS      = LINE_BYTES / (DATA_WIDTH / 8)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  output logic                       resp_valid,
  output logic [LINE_BYTES*8-1:0]    resp_line,
  output logic                       resp_err,
  output logic [AXI_ID_WIDTH-1:0]    arid,
  output logic [ADDR_WIDTH-1:0]      araddr,
  output logic [AXI_ARLEN_WIDTH-1:0] arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [AXI_ID_WIDTH-1:0]    rid,
  input  logic [DATA_WIDTH-1:0]      rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFS   = $clog2(LINE_BYTES);

  icache_refill_state_t state, state_nxt;

  logic [CNT_W-1:0]                 cnt;
  logic [BEATS-1:0][DATA_WIDTH-1:0] line_q;
  logic                             req_fire;
  logic                             beat_acc;
  logic                             beat_last;
  logic                             unused_ok;

  // Line offset bits of the miss address are don't-care.
  assign unused_ok = ^req_addr[OFS-1:0];

  assign req_fire  = (state == REFILL_IDLE) && req_valid;
  assign beat_acc  = (state == REFILL_R) && rvalid && (rid == AXI_ID);
  assign beat_last = (cnt == CNT_W'(BEATS - 1));
  assign resp_line = line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= REFILL_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      REFILL_IDLE: if (req_valid)                   state_nxt = REFILL_AR;
      REFILL_AR:   if (arvalid && arready)          state_nxt = REFILL_R;
      REFILL_R:    if (beat_acc && (beat_last || rlast)) state_nxt = REFILL_DONE;
      REFILL_DONE:                                  state_nxt = REFILL_IDLE;
      default:                                      state_nxt = REFILL_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      req_ready  <= (state_nxt == REFILL_IDLE);
      arvalid    <= (state_nxt == REFILL_AR);
      rready     <= (state_nxt == REFILL_R);
      resp_valid <= (state_nxt == REFILL_DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr  <= '0;
      arid    <= '0;
      arlen   <= '0;
      arsize  <= '0;
      arburst <= '0;
    end else if (req_fire) begin
      araddr  <= {req_addr[31:OFS], {OFS{1'b0}}};
      arid    <= AXI_ID;
      arlen   <= AXI_ARLEN_WIDTH'(BEATS - 1);
      arsize  <= AXI_SIZE_4B;
      arburst <= AXI_BURST_INCR;
    end
  end

  // Unreceived words keep stale data on early termination; the error flag covers that case.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      resp_err <= 1'b0;
      line_q   <= '0;
    end else if (req_fire) begin
      cnt      <= '0;
      resp_err <= 1'b0;
    end else if (beat_acc) begin
      line_q[cnt] <= rdata;
      cnt         <= cnt + 1'b1;
      if ((axi_resp_t'(rresp) != AXI_RESP_OKAY) || (rlast != beat_last))
        resp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_axi_refill.sv
// Scoreboarded bench: request driver + AXI slave model feed expectations, negedge monitor checks.
module tb_icache_axi_refill;
  import icache_axi_refill_pkg::*;

  localparam int BEATS = 8;
  localparam logic [3:0] ID = 4'd0;

  logic         clk, rst_n;
  logic         req_valid, req_ready, resp_valid, resp_err;
  logic [31:0]  req_addr;
  logic [255:0] resp_line;
  logic [3:0]   arid, rid;
  logic [31:0]  araddr, rdata;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst, rresp;
  logic         arvalid, arready, rlast, rvalid, rready;

  icache_axi_refill #(.AXI_ID(ID)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_line(resp_line), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [255:0] line; logic err; int lat; } exp_t;
  // kind: 0 idle cycle, 1 foreign-ID beat, 2 real beat
  typedef struct { logic [1:0] kind; logic [31:0] data; logic [1:0] resp; logic last; } ent_t;

  exp_t        exp_q[$];
  logic [31:0] ar_q[$];
  int          ard_q[$];
  int          nent_q[$];
  ent_t        ent_q[$];
  logic [31:0] model [BEATS];
  int          n_chk = 0, n_fail = 0;
  int          req_cyc = 0;
  int          beats_sent = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_req_ready", 256'(req_ready), 256'(1));
    chk("rst_ctl", 256'({arvalid, rready, resp_valid, resp_err}), 256'(0));
    chk("rst_ar", 256'({araddr, arid, arlen, arsize, arburst}), 256'(0));
    chk("rst_line", resp_line, 256'(0));
  endtask

  task automatic flush();
    exp_q.delete(); ar_q.delete(); ard_q.delete(); nent_q.delete(); ent_q.delete();
  endtask

  // Builds the slave's beat plan and the expected line/error/latency from the burst rules.
  task automatic issue(input logic [31:0] addr, input bit seq, input int ard,
                       input logic [7:0] gap_m, input logic [7:0] frn_m,
                       input int err_b, input int early, input bit no_last);
    exp_t e;
    ent_t t;
    int   n_real, ne;
    logic err;
    n_real = (early >= 0) ? early + 1 : BEATS;
    err = 1'b0;
    ne = 0;
    for (int k = 0; k < n_real; k++) begin
      if (gap_m[k]) begin
        t.kind = 2'd0; t.data = $urandom; t.resp = 2'd0; t.last = 1'b0;
        ent_q.push_back(t); ne++;
      end
      if (frn_m[k]) begin
        t.kind = 2'd1; t.data = $urandom; t.resp = 2'($urandom_range(0, 3));
        t.last = 1'($urandom_range(0, 1));
        ent_q.push_back(t); ne++;
      end
      t.kind = 2'd2;
      t.data = seq ? 32'h1000 + 32'(k) : $urandom;
      t.resp = (k == err_b) ? 2'(2 + $urandom_range(0, 1)) : 2'd0;
      t.last = (k == early) || (k == BEATS - 1 && !no_last);
      model[k] = t.data;
      if (t.resp != 2'd0 || t.last != (k == BEATS - 1)) err = 1'b1;
      ent_q.push_back(t); ne++;
    end
    for (int k = 0; k < BEATS; k++) e.line[32*k +: 32] = model[k];
    e.err = err;
    e.lat = 10 + ard + (ne - BEATS);
    exp_q.push_back(e);
    ar_q.push_back({addr[31:5], 5'b0});
    ard_q.push_back(ard);
    nent_q.push_back(ne);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (req_ready) break;
    end
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) @(posedge clk);
    chk("timeout_pending", 256'(exp_q.size()), 256'(0));
    if (exp_q.size() > 0) flush();
  endtask

  // Monitor
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (req_valid && req_ready) req_cyc = cyc;
        if (arvalid) begin
          if (ar_q.size() == 0) chk("ar_unexpected", 256'(1), 256'(0));
          else begin
            chk("araddr", 256'(araddr), 256'(ar_q[0]));
            chk("ar_fields", 256'({arid, arlen, arsize, arburst}),
                256'({ID, 8'd7, 3'd2, 2'd1}));
            if (arready) void'(ar_q.pop_front());
          end
        end
        if (resp_valid) begin
          if (exp_q.size() == 0) chk("resp_unexpected", 256'(1), 256'(0));
          else begin
            e = exp_q.pop_front();
            chk("resp_line", resp_line, e.line);
            chk("resp_err", 256'(resp_err), 256'(e.err));
            chk("latency", 256'(cyc - req_cyc), 256'(e.lat));
          end
        end
      end
    end
  end

  // AXI slave model
  initial begin : slv
    int   phase, s_cnt, rem;
    ent_t t;
    arready = 1'b0; rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
    phase = 0; s_cnt = 0; rem = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; phase = 0;
      end else begin
        case (phase)
          0: if (arvalid && ard_q.size() > 0) begin
               s_cnt = ard_q.pop_front();
               rem   = nent_q.pop_front();
               arready = (s_cnt == 0);
               phase = (s_cnt == 0) ? 2 : 1;
             end
          1: begin
               s_cnt--;
               if (s_cnt == 0) begin arready = 1'b1; phase = 2; end
             end
          default: begin
               arready = 1'b0;
               if (rem > 0 && ent_q.size() > 0) begin
                 t = ent_q.pop_front();
                 rem--;
                 rvalid = (t.kind != 2'd0);
                 rid    = (t.kind == 2'd1) ? ID + 4'd1 : ID;
                 rdata  = t.data;
                 rresp  = t.resp;
                 rlast  = t.last;
                 if (t.kind == 2'd2) beats_sent++;
                 phase = 3;
               end else begin
                 rvalid = 1'b0; rlast = 1'b0; phase = 0;
               end
             end
        endcase
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0;
    for (int k = 0; k < BEATS; k++) model[k] = '0;
    repeat (3) @(posedge clk);
    #1 chk_reset();
    @(negedge clk) rst_n = 1'b1;

    issue(32'h0000_1234, 1, 0, 8'h00, 8'h00, -1, -1, 0); wait_done();  // basic
    issue(32'h8000_0047, 1, 3, 8'h48, 8'h00, -1, -1, 0); wait_done();  // stalls
    issue(32'h0000_2000, 1, 0, 8'h00, 8'h00,  4, -1, 0); wait_done();  // SLVERR beat 4
    issue(32'h0000_3010, 0, 0, 8'h00, 8'h00, -1,  3, 0); wait_done();  // early rlast
    issue(32'h0000_4000, 1, 0, 8'h00, 8'h10, -1, -1, 0); wait_done();  // foreign ID
    issue(32'h0000_5000, 0, 1, 8'h00, 8'h00, -1, -1, 1); wait_done();  // missing rlast

    // reset after beat 4 of a clean burst
    beats_sent = 0;
    issue(32'h0000_6000, 0, 0, 8'h00, 8'h00, -1, -1, 0);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (beats_sent >= 5) break;
    end
    chk("reset_beats_reached", 256'(beats_sent >= 5), 256'(1));
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1 chk_reset();
    flush();
    for (int k = 0; k < BEATS; k++) model[k] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    issue(32'h0000_1234, 1, 0, 8'h00, 8'h00, -1, -1, 0); wait_done();

    for (int n = 0; n < 30; n++) begin
      issue($urandom, 0, $urandom_range(0, 3),
            8'($urandom & $urandom), 8'($urandom & $urandom & $urandom),
            $urandom_range(0, 19) - 12,
            ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1,
            1'($urandom_range(0, 7) == 0));
      wait_done();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_axi_refill.md
# icache_axi_refill

AXI4 read-burst master that refills one instruction-cache line on a miss. Sits directly downstream of the icache miss logic and upstream of the AXI instruction memory. Accepts a line-aligned miss address, issues one INCR burst of `ICACHE_LINE_SIZE` bytes, assembles the returned beats into a full line, and returns it with an error flag.

## Interface

**Parameters**
- `AXI_ID`, default `4'd0`: ID driven on `arid`; only R beats carrying this ID are accepted.
- `LINE_BYTES`, default `ICACHE_LINE_SIZE` (32): bytes per line.
- `BEATS`, default `LINE_BYTES/(DATA_WIDTH/8)` (8): beats per burst.

**Ports**
- `clk` in 1: clock; single clock domain, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: miss request.
- `req_ready` out 1: block idle and able to accept a request.
- `req_addr` in 32: miss address; bits [ICACHE_LINE_OFFSET-1:0] are ignored.
- `resp_valid` out 1: one-cycle pulse; line is valid.
- `resp_line` out `LINE_BYTES*8`: assembled line, word k at bits [32k+31:32k].
- `resp_err` out 1: error flag, qualified by `resp_valid`.
- `arid` out `AXI_ID_WIDTH`: AXI read-address ID.
- `araddr` out `ADDR_WIDTH`: AXI read address.
- `arlen` out `AXI_ARLEN_WIDTH`: burst length minus one.
- `arsize` out 3: transfer size per beat.
- `arburst` out 2: burst type.
- `arvalid` out 1: read-address valid.
- `arready` in 1: read-address ready.
- `rid` in `AXI_ID_WIDTH`: read-data ID.
- `rdata` in `DATA_WIDTH`: read data.
- `rresp` in 2: read response.
- `rlast` in 1: last beat of burst.
- `rvalid` in 1: read-data valid.
- `rready` out 1: read-data ready.

## Operation

- State machine `REFILL_IDLE -> REFILL_AR -> REFILL_R -> REFILL_DONE -> REFILL_IDLE`.
- **REFILL_IDLE**
  - `req_ready`=1.
  - On `req_valid`: latch `{req_addr[31:5], 5'b0}`, clear the beat counter and sticky error, go to REFILL_AR.
- **REFILL_AR**
  - Drive `arvalid`=1 with the following values, all held stable until `arready`:
    - `arid`=`AXI_ID`
    - `araddr`=latched address
    - `arlen`=`BEATS-1` (8'd7)
    - `arsize`=`AXI_SIZE_4B`
    - `arburst`=`AXI_BURST_INCR`
  - On `arvalid && arready`: go to REFILL_R.
- **REFILL_R**
  - `rready`=1 throughout.
  - A beat is accepted when `rvalid && rid==AXI_ID`. It writes `rdata` to word[cnt], and the 3-bit counter increments.
  - Beats whose `rid` mismatches are consumed, dropped and not counted.
  - Error set (sticky) on any accepted beat with:
    - `rresp` != `AXI_RESP_OKAY`, or
    - `rlast` != (cnt==BEATS-1).
  - Go to REFILL_DONE on an accepted beat with cnt==BEATS-1, or an accepted beat with `rlast`=1 (early termination). Words not received retain stale data; `resp_err`=1 in that case.
- **REFILL_DONE**
  - `resp_valid`=1 for exactly one cycle, then go to REFILL_IDLE.
  - `resp_line` and `resp_err` stay stable until the next request is accepted.
- Requests arriving while not idle are not accepted (`req_ready`=0). The requester holds `req_valid`.

## Timing

- Reset values: state REFILL_IDLE, `req_ready`=1, all of the following 0:
  - `arvalid`, `rready`, `resp_valid`, `resp_err`
  - `araddr`, `arid`, `arlen`, `arsize`, `arburst`
  - `resp_line`
- Best-case latency with `arready`=1 and back-to-back `rvalid`:
  - request accepted at cycle 0;
  - `arvalid` at cycle 1;
  - beats at cycles 2–9;
  - `resp_valid` at cycle 10.
- Each cycle of `arready`=0, `rvalid`=0, or a mismatched-ID beat adds one cycle.
- Back-to-back requests: the next request can be accepted the cycle after `resp_valid`. Minimum issue interval is 11 cycles.
- Reset asserted mid-burst: immediate return to reset values; the outstanding AXI transaction is abandoned, and the slave shares the same reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure

- Additions to `_pkg_riscv_defines`:
  - `typedef enum logic [1:0] {REFILL_IDLE, REFILL_AR, REFILL_R, REFILL_DONE} icache_refill_state_t`
  - `parameter ICACHE_REFILL_BEATS = ICACHE_LINE_SIZE/(DATA_WIDTH/8)`
- Reuse the existing package types `axi_burst_type_t`, `axi_size_t` and `axi_resp_t`.
- Single module; no sub-module. The line buffer is an array of `BEATS` words inside the module.

## Test plan

- **Basic refill:** `req_addr`=0x0000_1234, slave returns 0x1000+k on beat k with `arready`=1 and no stalls.
  - AR carries `araddr`=0x0000_1220, `arlen`=7, `arsize`=2, `arburst`=1.
  - `resp_valid` at cycle 10; word k = 0x1000+k; `resp_err`=0.
- **Stalls:** 3-cycle `arready` delay plus `rvalid` gaps after beats 2 and 5.
  - Line is correct; `resp_valid` arrives 5 cycles later than the basic case; AR fields stay stable while stalled.
- **Error response:** `rresp`=SLVERR on beat 4.
  - All 8 beats are consumed; `resp_err`=1; the line still contains all beats.
- **Early rlast:** `rlast`=1 on beat 3.
  - `resp_valid` follows the next cycle with `resp_err`=1.
- **Foreign ID:** a beat with `rid`=AXI_ID+1 is inserted mid-burst.
  - The beat is dropped; the line is correct; `resp_err`=0.
- **Reset mid-burst:** `rst_n` low after beat 4, then a new request.
  - All outputs return to reset values immediately; the new refill completes normally.
